uart_rx: RTL and testbench

//  Receives 8N1 asynchronous serial characters on a single RX pin and presents each

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises the RX pin, samples each bit at mid-period and
// hands complete bytes to a valid/ready consumer with sticky framing/overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clear_err,
    output logic       busy,
    output logic [2:0] o_dbg_state
);

    // Handshake: a byte transfers on every clk edge where rx_valid && rx_ready are both
    // high; rx_data holds steady while rx_valid is high and changes only when a byte loads.

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;

    logic w_rxs;
    logic w_cnt_clr;
    logic w_bit_clr;
    logic w_shift_en;
    logic w_byte_done;
    logic w_frame_evt;
    logic w_load;

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_evt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rxs) w_next_state = START;
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_clr = 1'b1;
                    // A start bit that is high again at mid-period was only a glitch.
                    if (w_rxs) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DATA;
                        w_bit_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_next_state = STOP;
                end
            end
            STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_clr = 1'b1;
                    if (w_rxs) begin
                        w_byte_done  = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_frame_evt  = 1'b1;
                        w_next_state = BRK;
                    end
                end
            end
            BRK: begin
                w_cnt_clr = 1'b1;
                if (w_rxs) w_next_state = IDLE;
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '1;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], UART_RX};
            if (w_cnt_clr) r_cnt <= '0;
            else           r_cnt <= r_cnt + CW'(1);
            if (w_bit_clr)       r_bit_idx <= 3'd0;
            else if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;
            // LSB arrives first, so shift right; after eight bits it sits in bit 0.
            if (w_shift_en) r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

    assign w_load = w_byte_done && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // Error events take priority over a coincident clear.
            if (w_byte_done && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (clear_err)                       overrun <= 1'b0;
            if (w_frame_evt)    frame_err <= 1'b1;
            else if (clear_err) frame_err <= 1'b0;
        end
    end

    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives framed 8N1 characters at 16 clocks per bit and checks
// accepted bytes, flags and timing against expectations computed in the bench.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       clear_err;
    logic       busy;
    logic [2:0] o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic       prev_taken = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .UART_RX     (UART_RX),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clear_err   (clear_err),
        .busy        (busy),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 2 time units after posedge, so at negedge we see what the next edge will.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_taken && rx_valid && rx_data !== prev_data) begin
                n_err++;
                $display("FAIL data_stable: rx_data=%h was %h while valid", rx_data, prev_data);
            end
        end
        prev_valid = rx_valid && !reset;
        prev_taken = rx_valid && rx_ready;
        prev_data  = rx_data;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        last_start = cyc;
        UART_RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            wait_cycles(CPB);
        end
        UART_RX = stop_b;
        wait_cycles(CPB);
    endtask

    task automatic test_reset;
        reset = 1'b1; UART_RX = 1'b1; rx_ready = 1'b1; clear_err = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        n_vec++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: data=%h valid=%b fe=%b ov=%b busy=%b, want all 0",
                     rx_data, rx_valid, frame_err, overrun, busy);
        end
        n_vec++;
        if (o_dbg_state !== 3'd0) begin
            n_err++; $display("FAIL reset_state: state=%0d want 0", o_dbg_state);
        end
    endtask

    task automatic test_single;
        exp_q.delete(); got_q.delete(); rise_cyc = -1;
        send_frame(8'h57, 1'b1);
        wait_cycles(4);
        n_vec++;
        if (got_q.size() != 1 || got_q[0] !== 8'h57) begin
            n_err++; $display("FAIL single_byte: got %0d bytes first=%h want 1 byte 57", got_q.size(),
                              got_q.size() > 0 ? got_q[0] : 8'hxx);
        end
        n_vec++;
        if (rise_cyc - last_start < LAT - 1 || rise_cyc - last_start > LAT + 1) begin
            n_err++; $display("FAIL latency: %0d cycles want %0d +/-1", rise_cyc - last_start, LAT);
        end
        n_vec++;
        if ({frame_err, overrun, busy, rx_valid} !== 4'b0000) begin
            n_err++; $display("FAIL single_after: fe=%b ov=%b busy=%b valid=%b want 0000",
                              frame_err, overrun, busy, rx_valid);
        end
    endtask

    task automatic check_stream(input string name);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL %s_count: got %0d bytes want %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        send_frame(8'h0D, 1'b1);
        send_frame(8'h0A, 1'b1);
        wait_cycles(4);
        check_stream("b2b");
    endtask

    task automatic test_random_stream;
        logic [7:0] b;
        exp_q.delete(); got_q.delete();
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            wait_cycles($urandom_range(0, 3));
        end
        wait_cycles(4);
        check_stream("rand");
    endtask

    task automatic test_glitch;
        got_q.delete();
        UART_RX = 1'b0;
        wait_cycles(4);
        UART_RX = 1'b1;
        wait_cycles(30);
        n_vec++;
        if (got_q.size() != 0 || rx_valid || frame_err || overrun || busy) begin
            n_err++; $display("FAIL glitch: bytes=%0d valid=%b fe=%b ov=%b busy=%b want none",
                              got_q.size(), rx_valid, frame_err, overrun, busy);
        end
    endtask

    task automatic test_frame_error;
        got_q.delete();
        send_frame(8'h41, 1'b0);
        wait_cycles(40);
        n_vec++;
        if (frame_err !== 1'b1 || got_q.size() != 0) begin
            n_err++; $display("FAIL frame_flag: fe=%b bytes=%0d want fe=1 bytes=0", frame_err, got_q.size());
        end
        n_vec++;
        if (busy !== 1'b1 || o_dbg_state !== 3'd4) begin
            n_err++; $display("FAIL frame_break: busy=%b state=%0d want busy=1 state=4", busy, o_dbg_state);
        end
        UART_RX = 1'b1;
        wait_cycles(20);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL break_exit: busy=%b want 0", busy);
        end
        exp_q.delete(); exp_q.push_back(8'h30);
        send_frame(8'h30, 1'b1);
        wait_cycles(4);
        check_stream("after_break");
        n_vec++;
        if (frame_err !== 1'b1) begin
            n_err++; $display("FAIL frame_sticky: fe=%b want 1", frame_err);
        end
        clear_err = 1'b1;
        wait_cycles(1);
        clear_err = 1'b0;
        n_vec++;
        if (frame_err !== 1'b0) begin
            n_err++; $display("FAIL frame_clear: fe=%b want 0", frame_err);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] a, b;
        a = 8'h30; b = 8'h31;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            end
            got_q.delete();
            rx_ready = 1'b0;
            send_frame(a, 1'b1);
            send_frame(b, 1'b1);
            wait_cycles(4);
            n_vec++;
            if (rx_data !== a || rx_valid !== 1'b1 || overrun !== 1'b1 || got_q.size() != 0) begin
                n_err++; $display("FAIL overrun_hold%0d: data=%h valid=%b ov=%b want data=%h valid=1 ov=1",
                                  pass, rx_data, rx_valid, overrun, a);
            end
            rx_ready = 1'b1;
            wait_cycles(1);
            rx_ready = 1'b0;
            wait_cycles(1);
            n_vec++;
            if (rx_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== a) begin
                n_err++; $display("FAIL overrun_consume%0d: valid=%b bytes=%0d want valid=0 one byte %h",
                                  pass, rx_valid, got_q.size(), a);
            end
            clear_err = 1'b1;
            wait_cycles(1);
            clear_err = 1'b0;
            rx_ready = 1'b1;
            n_vec++;
            if (overrun !== 1'b0) begin
                n_err++; $display("FAIL overrun_clear%0d: ov=%b want 0", pass, overrun);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        got_q.delete();
        UART_RX = 1'b0;
        wait_cycles(CPB);
        UART_RX = 1'b1;
        wait_cycles(4 * CPB + CPB / 2);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_frame_busy: busy=%b want 1", busy);
        end
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        n_vec++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000 || o_dbg_state !== 3'd0) begin
            n_err++; $display("FAIL reset_mid: data=%h valid=%b fe=%b ov=%b busy=%b state=%0d want 0",
                              rx_data, rx_valid, frame_err, overrun, busy, o_dbg_state);
        end
        wait_cycles(4 * CPB);
        n_vec++;
        if (got_q.size() != 0 || rx_valid || frame_err) begin
            n_err++; $display("FAIL reset_no_partial: bytes=%0d valid=%b fe=%b want none",
                              got_q.size(), rx_valid, frame_err);
        end
        exp_q.delete(); exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_cycles(4);
        check_stream("post_reset");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_random_stream;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
